osd_cmd_tx: RTL
===============

OSD_CMD_TX -- requirements
Module: osd_cmd_tx

Interface
REQ-001 The block SHALL have parameter STROBE_HI, default 2, the number of clk_sys cycles io_strobe is held high per word (legal range 1-15).
REQ-002 The block SHALL have parameter STROBE_LO, default 2, the number of clk_sys cycles io_strobe is held low after each high phase (legal range 1-15).
REQ-003 The block SHALL have parameter GAP, default 4, the number of clk_sys cycles io_osd is held low after each transaction (legal range 1-15).
REQ-004 clk_sys  input  1  sole clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  a command request is present.
REQ-007 cmd_ready  output  1  the block accepts a command this cycle.
REQ-008 cmd_byte  input  8  command byte, such as 0x40/0x41 enable/disable or 0x20-0x3F write.
REQ-009 cmd_len  input  13  number of payload words that follow the command (0-8191).
REQ-010 pay_valid  input  1  a payload word is present.
REQ-011 pay_ready  output  1  the block consumes a payload word this cycle.
REQ-012 pay_data  input  16  payload word.
REQ-013 io_osd  output  1  transaction frame, high for the whole transaction.
REQ-014 io_strobe  output  1  word strobe; the far end samples io_din on its rising edge.
REQ-015 io_din  output  16  command or payload word.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on entering GAP.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The FSM states SHALL be IDLE, SETUP, HI, LO, FETCH and GAP.
REQ-020 In IDLE, cmd_ready SHALL be 1; all other outputs except io_din SHALL be 0.
REQ-021 On a cmd_valid&cmd_ready handshake, the block SHALL latch {8'h00,cmd_byte} into io_din and latch cmd_len into a remaining-word counter.
REQ-022 On that handshake the block SHALL set io_osd=1 and go to SETUP.
REQ-023 SETUP SHALL last exactly 1 cycle with io_strobe=0, then go to HI.
REQ-024 In HI, io_strobe SHALL be 1 for STROBE_HI cycles, then the block SHALL go to LO.
REQ-025 In LO, io_strobe SHALL be 0 for STROBE_LO cycles, then the block SHALL go to FETCH if remaining>0, else to GAP.
REQ-026 In FETCH, pay_ready SHALL be 1 and the block SHALL wait for pay_valid with no timeout, holding io_osd=1 and io_strobe=0.
REQ-027 On a FETCH handshake, the block SHALL load pay_data into io_din, decrement remaining, and go to SETUP.
REQ-028 pay_ready SHALL be 1 only in FETCH, so at most one word is consumed per strobe.
REQ-029 io_din SHALL change only while io_strobe=0, at least 1 cycle before io_strobe rises, and SHALL be stable throughout HI.
REQ-030 In GAP, io_osd and io_strobe SHALL be 0 for GAP cycles, and done SHALL pulse in the first GAP cycle.
REQ-031 At the end of GAP the block SHALL return to IDLE, and cmd_ready SHALL be 1 in the following cycle.
REQ-032 With cmd_len=0, the block SHALL send exactly one strobe (the command) and then enter GAP.
REQ-033 Strobes per transaction SHALL equal cmd_len+1, and the counter SHALL not wrap; cmd_len=8191 SHALL yield 8192 strobes.
REQ-034 Timing: with no payload stalls, transaction length SHALL be (cmd_len+1)*(1+STROBE_HI+STROBE_LO) + cmd_len*1 (FETCH) + GAP cycles.
REQ-035 cmd_valid asserted outside IDLE SHALL be ignored and not queued.
REQ-036 cmd_byte and cmd_len SHALL be sampled only on the handshake, so later changes have no effect.
REQ-037 pay_valid asserted outside FETCH SHALL have no effect.
REQ-038 Phase counters SHALL be 4 bits wide, and the remaining-word counter SHALL be 13 bits wide.

Reset
REQ-039 Reset asserted at any time, including mid-transaction, SHALL force state IDLE on the next edge.
REQ-040 On reset the block SHALL drive io_osd=0, io_strobe=0, io_din=0, pay_ready=0, busy=0 and done=0, with cmd_ready=1 in the first cycle after reset deasserts.
REQ-041 A transaction interrupted by reset SHALL not resume, and no done pulse SHALL be issued for it.

Verification
REQ-042 The bench SHALL apply cmd_byte=0x41, cmd_len=0 and require: one strobe with io_din=0x0041, io_osd high for 1+2+2=5 cycles, done pulse, cmd_ready 4 cycles later.
REQ-043 The bench SHALL apply cmd_byte=0x40, cmd_len=5, payload 0x0010,0x0020,0x0040,0x0008,0x0003 and require: 6 strobes carrying 0x0040 then those values in order, and io_osd low for 4 cycles after.
REQ-044 The bench SHALL apply cmd_byte=0x28, cmd_len=256, with pay_valid toggling pseudo-randomly, and require: 257 strobes, io_din never changing while io_strobe=1, and no word lost or duplicated.
REQ-045 The bench SHALL hold cmd_valid high throughout a cmd_len=3 transaction and require: cmd_ready=0 and no second transaction until after GAP.
REQ-046 The bench SHALL assert reset during the HI phase of payload word 2 and require: io_osd=0 and io_strobe=0 on the next cycle, no done pulse, and a normal transaction on the next command.
REQ-047 The bench SHALL connect the block to the OSD receiver and send an enable command with 5 info words and require: the receiver latches infox/infoy/infow/infoh/rot equal to the sent values.

Source files
------------

// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: serialises one command word plus cmd_len payload words onto the
// OSD parallel bus. io_osd frames the whole transaction and io_strobe pulses
// once per word. io_din is only updated while io_strobe is low, so the far end
// sees a stable word on every rising strobe.
module osd_cmd_tx #(
    parameter int STROBE_HI = 2,
    parameter int STROBE_LO = 2,
    parameter int GAP       = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic [12:0] cmd_len,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [15:0] pay_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);

    // Phase counters count down to zero, so they are loaded with length-1.
    localparam logic [3:0] HI_LOAD  = 4'(STROBE_HI - 1);
    localparam logic [3:0] LO_LOAD  = 4'(STROBE_LO - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HI,
        S_LO,
        S_FETCH,
        S_GAP
    } state_t;

    state_t      state;
    logic [3:0]  phase_cnt;
    logic [12:0] remaining;

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= 4'd0;
            remaining <= 13'd0;
            cmd_ready <= 1'b1;
            pay_ready <= 1'b0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        io_din    <= {8'h00, cmd_byte};
                        remaining <= cmd_len;
                        io_osd    <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    io_strobe <= 1'b1;
                    phase_cnt <= HI_LOAD;
                    state     <= S_HI;
                end
                S_HI: begin
                    if (phase_cnt == 4'd0) begin
                        io_strobe <= 1'b0;
                        phase_cnt <= LO_LOAD;
                        state     <= S_LO;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_LO: begin
                    if (phase_cnt == 4'd0) begin
                        if (remaining != 13'd0) begin
                            pay_ready <= 1'b1;
                            state     <= S_FETCH;
                        end else begin
                            io_osd    <= 1'b0;
                            done      <= 1'b1;
                            phase_cnt <= GAP_LOAD;
                            state     <= S_GAP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_FETCH: begin
                    if (pay_valid && pay_ready) begin
                        io_din    <= pay_data;
                        remaining <= remaining - 13'd1;
                        pay_ready <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_GAP: begin
                    if (phase_cnt == 4'd0) begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                default: begin
                    io_osd    <= 1'b0;
                    io_strobe <= 1'b0;
                    pay_ready <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
